// File: rtl/dispatch_decode_queue.sv
// dispatch_decode_queue: buffered RV32 decode stage routing entries to four reservation-queue channels
module dispatch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W = 32,
  parameter int MUL_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [3:0]               q_full,
  output logic                     out_valid,
  output logic [3:0]               out_qsel,
  output logic [31:0]              out_inst,
  output logic [PC_W-1:0]          out_pc,
  output logic [2:0]               out_inst_type,
  output logic [1:0]               out_alu_op,
  output logic                     out_jump,
  output logic                     out_jumpr,
  output logic                     out_branch,
  output logic                     out_memread,
  output logic                     out_memwrite,
  output logic                     out_alusrc,
  output logic                     out_regwrite,
  output logic                     out_pcsave,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   buf_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic [31:0]     head;
  logic            push, pop, is_mul;
  logic [2:0]      d_type;
  logic [1:0]      d_alu;
  logic [7:0]      d_flags, flags;
  logic [3:0]      d_qsel;
  logic            d_illegal;
  assign head = inst_mem[rptr];
  assign in_ready = count < CW'(DEPTH);
  assign push = in_valid & in_ready;
  assign pop = (count != '0) & (d_illegal | ~|(d_qsel & q_full));
  assign buf_count = count;
  assign is_mul = (MUL_EN != 0) && (head[31:25] == 7'b0000001);
  assign {out_jump, out_jumpr, out_branch, out_memread, out_memwrite, out_alusrc, out_regwrite, out_pcsave} = flags;
  // flag order: jump, jumpr, branch, memread, memwrite, alusrc, regwrite, pcsave
  always_comb begin
    {d_type, d_alu, d_flags, d_qsel} = '0;
    d_illegal = 1'b0;
    if (head[1:0] != 2'b11) d_illegal = 1'b1;
    else case (head[6:0])
      7'h33: {d_type, d_alu, d_flags, d_qsel} = is_mul ? {3'b111, 2'b11, 8'b0000_0010, 4'b1000}
                                                       : {3'b111, 2'b10, 8'b0000_0010, 4'b0001};
      7'h13: {d_type, d_alu, d_flags, d_qsel} = {3'b000, 2'b10, 8'b0000_0110, 4'b0001};
      7'h03: {d_type, d_alu, d_flags, d_qsel} = {3'b000, 2'b00, 8'b0001_0110, 4'b0010};
      7'h23: {d_type, d_alu, d_flags, d_qsel} = {3'b010, 2'b00, 8'b0000_1100, 4'b0010};
      7'h63: {d_type, d_alu, d_flags, d_qsel} = {3'b011, 2'b01, 8'b0010_0000, 4'b0100};
      7'h6F: {d_type, d_alu, d_flags, d_qsel} = {3'b100, 2'b00, 8'b1000_0010, 4'b0001};
      7'h67: {d_type, d_alu, d_flags, d_qsel} = {3'b000, 2'b00, 8'b0100_0110, 4'b0001};
      7'h37: {d_type, d_alu, d_flags, d_qsel} = {3'b101, 2'b00, 8'b0000_0010, 4'b0001};
      7'h17: {d_type, d_alu, d_flags, d_qsel} = {3'b101, 2'b00, 8'b0000_0011, 4'b0001};
      default: d_illegal = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wptr] <= in_inst;
      pc_mem[wptr] <= in_pc;
    end
  end
  // reset and flush both empty the queue and clear the dispatch register
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      out_valid <= 1'b0;
      out_qsel <= '0;
      out_inst <= '0;
      out_pc <= '0;
      out_inst_type <= '0;
      out_alu_op <= '0;
      flags <= '0;
      out_illegal <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      out_valid <= pop;
      if (pop) begin
        out_qsel <= d_qsel;
        out_inst <= head;
        out_pc <= pc_mem[rptr];
        out_inst_type <= d_type;
        out_alu_op <= d_alu;
        flags <= d_flags;
        out_illegal <= d_illegal;
      end
    end
  end
endmodule
